// File: rtl/rf_pkg.sv
// Shared definitions for the register file and the stages that talk to it.
//   rf_state_t : clear-sweep state machine encoding
//   RF_DATA_W  : default register width
//   RF_DEPTH   : default number of architectural registers
package rf_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_DEPTH  = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard for load-use hazard detection.
//   clk, rst  : clock, synchronous active-high reset (clears every pending bit)
//   en        : high when the register file is idle; updates are ignored otherwise
//   WE, WA    : writeback write, clears the pending bit of WA
//   SET_PEND  : marks register PA as awaiting a write (wins over a same-edge clear)
//   RA        : packed read addresses, one AW-bit field per read port
//   PEND      : per-port pending flag, masked by a same-cycle write to that address
module rf_scoreboard import rf_pkg::*; #(
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            WE,
    input  logic [AW-1:0]   WA,
    input  logic            SET_PEND,
    input  logic [AW-1:0]   PA,
    input  logic [NREAD*AW-1:0] RA,
    output logic [NREAD-1:0] PEND
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [DEPTH-1:0] pend;
    logic             clr_ok;
    logic             set_ok;

    assign clr_ok = en && WE && !(ZR && WA == '0);
    assign set_ok = en && SET_PEND && !(ZR && PA == '0);

    // The set is written last so it overrides a same-edge clear of the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (clr_ok) pend[WA] <= 1'b0;
            if (set_ok) pend[PA] <= 1'b1;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        PEND = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra = RA[i*AW +: AW];
            PEND[i] = en && pend[ra] && !(WE && WA == ra) && !(ZR && ra == '0);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass, optional hardwired
// zero register, a sequential clear sweep after reset and a pending-write
// scoreboard.
//   clk, rst  : clock, synchronous active-high reset (restarts the clear sweep)
//   WE/WA/WD  : write port, applied at the rising edge while idle
//   RA / RD   : NREAD packed read addresses / combinational read data
//   SET_PEND/PA : mark register PA as having an outstanding write
//   PEND      : per-read-port outstanding-write flag
//   BUSY      : clear sweep in progress; writes and pend sets are ignored
module regfile_mp import rf_pkg::*; #(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    WE,
    input  logic [AW-1:0]           WA,
    input  logic [DATA_W-1:0]       WD,
    input  logic [NREAD*AW-1:0]     RA,
    output logic [NREAD*DATA_W-1:0] RD,
    input  logic                    SET_PEND,
    input  logic [AW-1:0]           PA,
    output logic [NREAD-1:0]        PEND,
    output logic                    BUSY
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t         state;
    logic [AW-1:0]     cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign BUSY  = (state == RF_CLEAR);
    assign wr_ok = !BUSY && WE && !(ZR && WA == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else if (state == RF_CLEAR) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                state <= RF_IDLE;
            end else begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    // Storage has no reset; the sweep zeroes one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (BUSY) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                mem[WA] <= WD;
            end
        end
    end

    always_comb begin
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] val;
        RD = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra = RA[i*AW +: AW];
            if (BUSY) begin
                val = '0;
            end else if (ZR && ra == '0) begin
                val = '0;
            end else if (BYP && WE && WA == ra) begin
                val = WD;
            end else begin
                val = mem[ra];
            end
            RD[i*DATA_W +: DATA_W] = val;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .en       (!BUSY),
        .WE       (WE),
        .WA       (WA),
        .SET_PEND (SET_PEND),
        .PA       (PA),
        .RA       (RA),
        .PEND     (PEND)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (default config, and NREAD=4/DEPTH=16
// without a zero register). Expected outputs are predicted from a plain array
// model and queued; a negedge monitor pops and compares them.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: defaults (DATA_W=32, DEPTH=32, NREAD=2, ZERO_REG=1, BYPASS=1)
    logic        rst_a, we_a, sp_a, busy_a;
    logic [4:0]  wa_a, pa_a;
    logic [31:0] wd_a;
    logic [9:0]  ra_a;
    logic [63:0] rd_a;
    logic [1:0]  pend_a;

    // instance B: NREAD=4, DEPTH=16, ZERO_REG=0
    logic         rst_b, we_b, sp_b, busy_b;
    logic [3:0]   wa_b, pa_b;
    logic [31:0]  wd_b;
    logic [15:0]  ra_b;
    logic [127:0] rd_b;
    logic [3:0]   pend_b;

    regfile_mp u_dut_a (
        .clk(clk), .rst(rst_a), .WE(we_a), .WA(wa_a), .WD(wd_a), .RA(ra_a), .RD(rd_a),
        .SET_PEND(sp_a), .PA(pa_a), .PEND(pend_a), .BUSY(busy_a)
    );

    regfile_mp #(
        .DATA_W(32), .DEPTH(16), .NREAD(4), .ZERO_REG(0), .BYPASS(1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .WE(we_b), .WA(wa_b), .WD(wd_b), .RA(ra_b), .RD(rd_b),
        .SET_PEND(sp_b), .PA(pa_b), .PEND(pend_b), .BUSY(busy_b)
    );

    typedef struct {
        bit          rst, we, sp;
        int          wa, pa;
        logic [31:0] wd;
        int          ra[4];
    } stim_t;

    typedef struct {
        int          dut;
        logic [63:0] name;
        logic [31:0] rd[4];
        bit          pend[4];
        bit          busy;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    int depth[2] = '{32, 16};
    int nread[2] = '{2, 4};
    bit zero[2]  = '{1'b1, 1'b0};

    // reference model: register contents, pending flags, remaining sweep cycles
    logic [31:0] mmem[2][32];
    bit          mpend[2][32];
    int          busy_left[2];
    bit          known[2];

    stim_t       cur[2];
    logic [63:0] tag;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.we = 0; s.sp = 0; s.wa = 0; s.pa = 0; s.wd = '0;
        for (int i = 0; i < 4; i++) s.ra[i] = 0;
        return s;
    endfunction

    task automatic drive();
        rst_a = cur[0].rst; we_a = cur[0].we; sp_a = cur[0].sp;
        wa_a = 5'(cur[0].wa); pa_a = 5'(cur[0].pa); wd_a = cur[0].wd;
        for (int i = 0; i < 2; i++) ra_a[i*5 +: 5] = 5'(cur[0].ra[i]);
        rst_b = cur[1].rst; we_b = cur[1].we; sp_b = cur[1].sp;
        wa_b = 4'(cur[1].wa); pa_b = 4'(cur[1].pa); wd_b = cur[1].wd;
        for (int i = 0; i < 4; i++) ra_b[i*4 +: 4] = 4'(cur[1].ra[i]);
    endtask

    task automatic predict(input int d);
        exp_t  e;
        stim_t s = cur[d];
        e.dut  = d;
        e.name = tag;
        e.busy = (busy_left[d] > 0);
        for (int i = 0; i < 4; i++) begin
            if (e.busy || (zero[d] && s.ra[i] == 0)) begin
                e.rd[i] = '0; e.pend[i] = 0;
            end else if (s.we && s.wa == s.ra[i]) begin
                e.rd[i] = s.wd; e.pend[i] = 0;
            end else begin
                e.rd[i] = mmem[d][s.ra[i]]; e.pend[i] = mpend[d][s.ra[i]];
            end
        end
        q.push_back(e);
    endtask

    task automatic update(input int d);
        stim_t s = cur[d];
        if (s.rst) begin
            busy_left[d] = depth[d];
            known[d] = 1;
            for (int r = 0; r < 32; r++) begin
                mmem[d][r] = '0; mpend[d][r] = 0;
            end
        end else if (busy_left[d] > 0) begin
            busy_left[d]--;
        end else begin
            if (s.we && !(zero[d] && s.wa == 0)) begin
                mmem[d][s.wa] = s.wd; mpend[d][s.wa] = 0;
            end
            if (s.sp && !(zero[d] && s.pa == 0)) mpend[d][s.pa] = 1;
        end
    endtask

    task automatic cycle();
        drive();
        for (int d = 0; d < 2; d++) if (known[d]) predict(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) update(d);
        #1;
    endtask

    task automatic go(input int d, input stim_t s, input logic [63:0] name);
        tag = name;
        cur[d] = s;
        cur[1-d] = idle();
        cycle();
    endtask

    function automatic stim_t rnd(input int d);
        stim_t s = idle();
        s.rst = ($urandom_range(0, 999) == 0);
        s.we  = $urandom_range(0, 1) == 1;
        s.wa  = $urandom_range(0, depth[d]-1);
        s.wd  = $urandom;
        s.sp  = $urandom_range(0, 3) == 0;
        s.pa  = ($urandom_range(0, 3) == 0) ? s.wa : $urandom_range(0, depth[d]-1);
        for (int i = 0; i < 4; i++)
            s.ra[i] = ($urandom_range(0, 3) == 0) ? s.wa : $urandom_range(0, depth[d]-1);
        return s;
    endfunction

    task automatic check(input exp_t e);
        logic        gb;
        logic [31:0] gr;
        logic        gp;
        gb = (e.dut == 0) ? busy_a : busy_b;
        tests++;
        if (gb !== e.busy) begin
            fails++;
            $display("FAIL %s dut%0d busy got %b want %b t=%0t", e.name, e.dut, gb, e.busy, $time);
        end
        for (int i = 0; i < nread[e.dut]; i++) begin
            if (e.dut == 0) begin
                gr = rd_a[i*32 +: 32]; gp = pend_a[i];
            end else begin
                gr = rd_b[i*32 +: 32]; gp = pend_b[i];
            end
            tests++;
            if (gr !== e.rd[i]) begin
                fails++;
                $display("FAIL %s dut%0d rd%0d got %h want %h t=%0t", e.name, e.dut, i, gr, e.rd[i], $time);
            end
            tests++;
            if (gp !== e.pend[i]) begin
                fails++;
                $display("FAIL %s dut%0d pend%0d got %b want %b t=%0t", e.name, e.dut, i, gp, e.pend[i], $time);
            end
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) check(q.pop_front());
    end

    initial begin
        stim_t s;
        known[0] = 0; known[1] = 0; busy_left[0] = 0; busy_left[1] = 0;

        // both instances reset together; nothing checked before the first edge
        tag = "init";
        cur[0] = idle(); cur[0].rst = 1;
        cur[1] = idle(); cur[1].rst = 1;
        cycle();

        // 1: sweep length, reads during sweep, ignored write to x5
        s = idle(); s.rst = 1;
        go(0, s, "t1_rst");
        for (int c = 0; c < 34; c++) begin
            s = idle();
            s.ra[0] = c % 32; s.ra[1] = 5;
            if (c == 3) begin s.we = 1; s.wa = 5; s.wd = 32'hDEAD; s.sp = 1; s.pa = 5; end
            go(0, s, "t1_swp");
        end

        // 2: bypass, later read, zero register
        s = idle(); s.we = 1; s.wa = 7; s.wd = 32'h12345678; s.ra[0] = 7; s.ra[1] = 5;
        go(0, s, "t2_byp");
        s = idle(); s.ra[1] = 7;
        go(0, s, "t2_rd");
        s = idle(); s.we = 1; s.wa = 0; s.wd = 32'hFFFFFFFF; s.ra[0] = 0; s.ra[1] = 7;
        go(0, s, "t2_x0w");
        s = idle(); s.ra[0] = 0;
        go(0, s, "t2_x0r");

        // 3: pending set, same-cycle mask, cleared afterwards
        s = idle(); s.sp = 1; s.pa = 9;
        go(0, s, "t3_set");
        s = idle(); s.ra[0] = 9;
        go(0, s, "t3_pnd");
        s = idle(); s.we = 1; s.wa = 9; s.wd = 32'h99; s.ra[0] = 9;
        go(0, s, "t3_msk");
        s = idle(); s.ra[0] = 9;
        go(0, s, "t3_clr");

        // 4: same-edge set and write to x3
        s = idle(); s.sp = 1; s.pa = 3; s.we = 1; s.wa = 3; s.wd = 32'h55;
        go(0, s, "t4_both");
        s = idle(); s.ra[0] = 3; s.ra[1] = 3;
        go(0, s, "t4_chk");

        // 5: reset mid-sweep restarts it and clears pend bits
        s = idle(); s.sp = 1; s.pa = 12;
        go(0, s, "t5_pre");
        s = idle(); s.rst = 1;
        go(0, s, "t5_rst");
        for (int c = 0; c < 10; c++) begin
            s = rnd(0); s.rst = 0;
            go(0, s, "t5_swp");
        end
        s = idle(); s.rst = 1;
        go(0, s, "t5_rst2");
        for (int c = 0; c < 34; c++) begin
            s = rnd(0); s.rst = 0; s.ra[0] = 12; s.ra[1] = 3;
            go(0, s, "t5_swp2");
        end

        // random stream on instance A
        for (int c = 0; c < 2000; c++) go(0, rnd(0), "rnd_a");

        // 6: instance B, x0 is an ordinary register
        s = idle(); s.we = 1; s.wa = 0; s.wd = 32'hA5;
        go(1, s, "t6_x0w");
        s = idle();
        go(1, s, "t6_x0r");
        for (int c = 0; c < 10000; c++) go(1, rnd(1), "rnd_b");

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain queue got %0d want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
